udiv_seq: RTL and testbench

- Sequential restoring unsigned divider. Computes Q = I0 / I1 and R = I0 % I1 at one quotient bit per clock.
- Each step uses a WIDTH+1-bit subtract-with-carry-out as the "partial remainder >= divisor" test: COUT=1 means no borrow.
- Serves as the iterative arithmetic unit beside the combinational add/sub/compare library. It is used wherever a full-width combinational divider is too large.

---
 rtl/udiv_seq_if.sv | 23 ++
 rtl/udiv_seq.sv | 123 ++++++++++++
 tb/tb_udiv_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/udiv_seq_if.sv
// rtl/udiv_seq_if.sv - request/result bundle for the sequential unsigned divider
interface udiv_seq_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             READY;
    logic             VALID;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             DIVZ;

    modport master (
        output START, I0, I1,
        input  READY, VALID, Q, R, DIVZ
    );

    modport slave (
        input  START, I0, I1,
        output READY, VALID, Q, R, DIVZ
    );
endinterface

// File: rtl/udiv_seq.sv
// rtl/udiv_seq.sv - restoring unsigned divider, one quotient bit per clock; option UDIV_SEQ_EARLY_DIVZ_EN
module udiv_seq #(
    parameter int WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RESETN,
    udiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] d, d_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [CW-1:0]    count, count_n;
    logic             divz_r, divz_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic [WIDTH-1:0] r_r, r_n;
    logic             dz_r, dz_n;

    logic [WIDTH:0]   rem_sh;
    logic             carry;
    logic             diff_msb;
    logic [WIDTH-1:0] diff;
    logic             take;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state  <= IDLE;
            d      <= '0;
            quo    <= '0;
            rem    <= '0;
            count  <= '0;
            divz_r <= 1'b0;
            q_r    <= '0;
            r_r    <= '0;
            dz_r   <= 1'b0;
        end else begin
            state  <= state_n;
            d      <= d_n;
            quo    <= quo_n;
            rem    <= rem_n;
            count  <= count_n;
            divz_r <= divz_n;
            q_r    <= q_n;
            r_r    <= r_n;
            dz_r   <= dz_n;
        end
    end

    // One restoring step: shifted remainder minus divisor, carry-out set means no borrow.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        {carry, diff_msb, diff} = {1'b0, rem_sh} + {1'b0, ~{1'b0, d}}
                                + {{(WIDTH + 1){1'b0}}, 1'b1};
        // A successful subtract always leaves the result below d, so diff_msb is zero then.
        take     = carry & ~diff_msb;
        quo_step = {quo[WIDTH-2:0], take};
        rem_step = take ? diff : rem_sh[WIDTH-1:0];
    end

    always_comb begin
        state_n = state;
        d_n     = d;
        quo_n   = quo;
        rem_n   = rem;
        count_n = count;
        divz_n  = divz_r;
        q_n     = q_r;
        r_n     = r_r;
        dz_n    = dz_r;
        case (state)
            IDLE, DONE: begin
                if (bus.START) begin
                    d_n     = bus.I1;
                    quo_n   = bus.I0;
                    rem_n   = '0;
                    count_n = COUNT_INIT;
                    divz_n  = (bus.I1 == '0);
                    state_n = RUN;
`ifdef UDIV_SEQ_EARLY_DIVZ_EN
                    if (bus.I1 == '0) begin
                        count_n = '0;
                        q_n     = '1;
                        r_n     = bus.I0;
                        dz_n    = 1'b1;
                        state_n = DONE;
                    end
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                quo_n   = quo_step;
                rem_n   = rem_step;
                count_n = count - 1'b1;
                if (count == CW'(1)) begin
                    q_n     = quo_step;
                    r_n     = rem_step;
                    dz_n    = divz_r;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.READY = (state != RUN);
    assign bus.VALID = (state == DONE);
    assign bus.Q     = q_r;
    assign bus.R     = r_r;
    assign bus.DIVZ  = dz_r;
endmodule

// File: tb/tb_udiv_seq.sv
// tb/tb_udiv_seq.sv - self-checking bench for udiv_seq: vector table, corner sequences, random sweep
module tb_udiv_seq;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    always #5 CLK = ~CLK;

    udiv_seq_if #(.WIDTH(W)) bus ();
    udiv_seq #(.WIDTH(W)) dut (.CLK(CLK), .RESETN(RESETN), .bus(bus));

    int total = 0;
    int passed = 0;
    int valid_seen = 0;
    int accepted = 0;

    always @(negedge CLK) if (bus.VALID === 1'b1) valid_seen++;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef UDIV_SEQ_EARLY_DIVZ_EN
        if (b == 0) return 1;
`endif
        return W + 1;
    endfunction

    // Issue one operation; returns cycles from acceptance to VALID and READY-low cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int rdy_low);
        int guard = 0;
        while (bus.READY !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        bus.START = 1'b1;
        bus.I0 = a;
        bus.I1 = b;
        tick();
        accepted++;
        bus.START = 1'b0;
        lat = 1;
        rdy_low = 0;
        while (bus.VALID !== 1'b1 && lat < 50) begin
            if (bus.READY === 1'b0) rdy_low++;
            tick();
            lat++;
        end
        if (lat >= 50) check("valid_timeout", lat, 0);
    endtask

    initial begin
        vec_t vt[$];
        int lat, rl;
        logic [W-1:0] a, b, eq, er;

        vt.push_back('{8'd200, 8'd7,   8'd28,  8'd4,  1'b0});
        vt.push_back('{8'd5,   8'd9,   8'd0,   8'd5,  1'b0});
        vt.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0});
        vt.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0});
        vt.push_back('{8'd77,  8'd0,   8'd255, 8'd77, 1'b1});
        vt.push_back('{8'd0,   8'd5,   8'd0,   8'd0,  1'b0});
        vt.push_back('{8'd1,   8'd255, 8'd0,   8'd1,  1'b0});
        vt.push_back('{8'd128, 8'd2,   8'd64,  8'd0,  1'b0});

        bus.START = 1'b0;
        bus.I0 = '0;
        bus.I1 = '0;
        RESETN = 1'b0;
        tick();
        tick();
        RESETN = 1'b1;
        check("reset_ready", bus.READY, 1);
        check("reset_valid", bus.VALID, 0);
        check("reset_q", bus.Q, 0);
        check("reset_r", bus.R, 0);
        check("reset_divz", bus.DIVZ, 0);

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i].a, vt[i].b, lat, rl);
            check($sformatf("vec%0d_q", i), bus.Q, vt[i].q);
            check($sformatf("vec%0d_r", i), bus.R, vt[i].r);
            check($sformatf("vec%0d_divz", i), bus.DIVZ, vt[i].z);
            check($sformatf("vec%0d_latency", i), lat, exp_latency(vt[i].b));
            check($sformatf("vec%0d_ready_low", i), rl, exp_latency(vt[i].b) - 1);
            tick();
            check($sformatf("vec%0d_pulse_end", i), bus.VALID, 0);
        end

        // START during RUN is ignored; START held in DONE chains the next op.
        bus.START = 1'b1;
        bus.I0 = 8'd100;
        bus.I1 = 8'd3;
        tick();
        accepted++;
        bus.START = 1'b0;
        tick();
        tick();
        bus.START = 1'b1;
        bus.I0 = 8'd9;
        bus.I1 = 8'd2;
        tick();
        bus.START = 1'b0;
        lat = 4;
        while (bus.VALID !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        check("ignored_latency", lat, W + 1);
        check("ignored_q", bus.Q, 33);
        check("ignored_r", bus.R, 1);
        bus.START = 1'b1;
        bus.I0 = 8'd9;
        bus.I1 = 8'd2;
        tick();
        accepted++;
        bus.START = 1'b0;
        lat = 1;
        while (bus.VALID !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        check("b2b_latency", lat, W + 1);
        check("b2b_q", bus.Q, 4);
        check("b2b_r", bus.R, 1);
        tick();

        // Reset mid-RUN at count=4 discards the operation.
        valid_seen = 0;
        bus.START = 1'b1;
        bus.I0 = 8'd200;
        bus.I1 = 8'd7;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        check("midrst_ready", bus.READY, 1);
        check("midrst_valid", bus.VALID, 0);
        check("midrst_q", bus.Q, 0);
        check("midrst_r", bus.R, 0);
        for (int i = 0; i < 20; i++) tick();
        check("midrst_no_valid", valid_seen, 0);

        // Random sweep against plain arithmetic.
        valid_seen = 0;
        accepted = 0;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            eq = (b == 0) ? '1 : a / b;
            er = (b == 0) ? a : a % b;
            run_op(a, b, lat, rl);
            if (bus.Q !== eq || bus.R !== er || bus.DIVZ !== (b == 0) ||
                lat != exp_latency(b)) begin
                check("rand_q", bus.Q, eq);
                check("rand_r", bus.R, er);
                check("rand_divz", bus.DIVZ, (b == 0));
                check("rand_latency", lat, exp_latency(b));
            end else begin
                check("rand_result", 1, 1 - int'(bus.Q !== eq));
            end
        end
        tick();
        tick();
        check("rand_valid_count", valid_seen, accepted);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
